// File: rtl/sram_pkg.sv
// Shared constants for the SRAM host-side FIFO: default geometry and read-mode encoding.
package sram_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 16;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

endpackage : sram_pkg

// File: rtl/sram_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array, synchronous write, asynchronous read.
module sram_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Asynchronous read lets the top choose registered or fall-through presentation.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule : sram_fifo_mem

// File: rtl/sram_sync_fifo.sv
// Single-clock parametrised FIFO feeding the SRAM sequencer, with occupancy,
// threshold flags, sticky error flags and selectable standard/FWFT read.
module sram_sync_fifo
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2,
  parameter int FWFT       = MODE_STD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   input_data,
  input  logic                    write_enable,
  input  logic                    read_enable,
  output logic [DATA_WIDTH-1:0]   output_data,
  output logic                    output_valid,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_MARGIN);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  assign fifo_full    = (count_q == FULL_LEVEL);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= AF_LEVEL);
  assign almost_empty = (count_q <= AE_LEVEL);
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign rd_acc = read_enable & ~fifo_empty;
  assign wr_acc = write_enable & (~fifo_full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (write_enable & ~wr_acc);
    underflow_d = underflow_q | (read_enable & fifo_empty);
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sram_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (input_data),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      assign output_data  = rd_data;
      assign output_valid = ~fifo_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] out_data_q;
      logic                  out_valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= rd_acc;
          if (rd_acc) begin
            out_data_q <= rd_data;
          end
        end
      end

      assign output_data  = out_data_q;
      assign output_valid = out_valid_q;
    end
  endgenerate

endmodule : sram_sync_fifo

// File: doc/sram_sync_fifo.md
Name: sram_sync_fifo

Overview:
Single-clock, parametrised FIFO that buffers host words ahead of the SRAM controller's write/read sequencer. It succeeds the fixed 16x16 FIFO. It adds configurable width and depth, an occupancy count, and programmable almost-full and almost-empty thresholds. It also adds sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
DATA_WIDTH, 16, word width in bits
DEPTH, 16, number of entries; power of two, >= 2
AF_MARGIN, 2, almost_full asserts when count >= DEPTH - AF_MARGIN; range 0..DEPTH-1
AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN; range 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active low
input_data  input  DATA_WIDTH  write word
write_enable  input  1  write request
read_enable  input  1  read/pop request
output_data  output  DATA_WIDTH  read word
output_valid  output  1  output_data holds a valid word (see Behaviour)
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
almost_full  output  1  count >= DEPTH - AF_MARGIN
almost_empty  output  1  count <= AE_MARGIN
fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full and not popped
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low at a clk edge):
  - Pointers and count go to 0; fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
  - output_data=0, output_valid=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all queued words. An in-flight read in standard mode produces no output_valid.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. Address is the low bits; the MSB is the wrap bit.
  - Pointers wrap naturally at 2*DEPTH.
- Accept rules, evaluated in the same cycle:
  - rd_acc = read_enable & !fifo_empty
  - wr_acc = write_enable & (!fifo_full | rd_acc)
  - A simultaneous write and read while full are both accepted; count is unchanged.
  - A simultaneous write and read while empty: the write is accepted, the read is rejected and flags underflow.
- Count update:
  - +1 on wr_acc & !rd_acc.
  - -1 on rd_acc & !wr_acc.
  - Unchanged otherwise.
  - fifo_full, fifo_empty, almost_full and almost_empty decode combinationally from the count register, so they change on the same edge as the count.
- Error flags:
  - overflow sets on write_enable & !wr_acc.
  - underflow sets on read_enable & fifo_empty.
  - Both are cleared only by reset. Rejected operations never move pointers or corrupt data.
- Standard mode (FWFT=0):
  - On rd_acc, output_data <= mem[rd_addr] at the edge, and output_valid is high for exactly the following cycle.
  - Read latency is 1 cycle. output_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - output_data = mem[rd_addr] combinationally; output_valid = !fifo_empty.
  - read_enable acknowledges the presented word.
  - A word written into an empty FIFO appears on output_data the cycle after its write edge.
- Full throughput: one write and one read every cycle are sustainable at any occupancy between 1 and DEPTH-1.

Decomposition:
- Shared package sram_pkg holds:
  - default DATA_WIDTH and DEPTH constants
  - the FWFT mode encoding constants (MODE_STD=0, MODE_FWFT=1)
- One sub-module: sram_fifo_mem.
  - A DEPTH x DATA_WIDTH array with one synchronous write port and an asynchronous read port.
  - The top selects registered or fall-through output around it.

Test Plan:
- Reset, then write 16 words 256..271 (DEPTH=16, AF_MARGIN=2) -> fifo_count reaches 16.
  - almost_full rises on the 14th write edge; fifo_full rises on the 16th.
  - almost_empty falls on the 3rd write edge.
- Write a 17th word 999 while full -> it is rejected and overflow=1 sticky.
  - Reading 16 words then yields 256..271 in order, each one cycle after read_enable (output_valid pulses). fifo_empty=1 after the last read.
- Read while empty -> underflow=1, output_data unchanged, count remains 0.
- Fill to 16, then assert write and read together for 8 cycles with data 500..507 -> count stays 16, no overflow.
  - Draining then yields 264..271 followed by 500..507 (pointer wrap verified).
- FWFT=1: write 0x1234 into an empty FIFO -> the next cycle output_data=0x1234 and output_valid=1.
  - After one read_enable cycle, output_valid=0 and fifo_empty=1.
- Fill 5 words, pulse rst_n low for one edge -> count=0, fifo_empty=1, output_valid=0, overflow=0, underflow=0.
  - A subsequent write/read of 0xABCD returns 0xABCD.
